// File: rtl/traffic_pkg.sv
// ============================================================================
// Module      : traffic_pkg
// Description : Shared state encodings and lamp constants for the timed
//               highway/farm-road intersection controller.
//               Optional feature macro: TRAFFIC_PED_WALK_EN (adds WK state,
//               widens the state encoding to 3 bits).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package traffic_pkg;

  // Controller state encodings
  localparam int HG = 0;
  localparam int HY = 1;
  localparam int FG = 2;
  localparam int FY = 3;
  localparam int WK = 4;

  // Lamp vector bit positions, vector is {R,Y,G}
  localparam int LAMP_G = 0;
  localparam int LAMP_Y = 1;
  localparam int LAMP_R = 2;

  // One-hot lamp patterns built from the bit positions
  localparam logic [2:0] RED = 3'(1 << LAMP_R);
  localparam logic [2:0] YEL = 3'(1 << LAMP_Y);
  localparam logic [2:0] GRN = 3'(1 << LAMP_G);

  // Walk phase needs a fifth encoding, hence a wider state register
`ifdef TRAFFIC_PED_WALK_EN
  localparam int STATE_W = 3;
`else
  localparam int STATE_W = 2;
`endif

endpackage

`default_nettype wire

// File: rtl/traffic_timer.sv
// ============================================================================
// Module      : traffic_timer
// Description : Saturating interval counter. Clears when the controller
//               changes state, otherwise counts up to LONG_CYC-1 and holds.
//               ts flags the end of a yellow, tl the end of a long interval.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module traffic_timer #(
  parameter int LONG_CYC  = 10,
  parameter int SHORT_CYC = 3
) (
  input  logic clk,
  input  logic reset,
  input  logic clr,
  output logic ts,
  output logic tl
);

  localparam int CNT_W = $clog2(LONG_CYC + 1);
  localparam logic [CNT_W-1:0] LONG_M1  = CNT_W'(LONG_CYC - 1);
  localparam logic [CNT_W-1:0] SHORT_M1 = CNT_W'(SHORT_CYC - 1);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  // Next count: clear on a state change, otherwise count up and saturate
  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (cnt_q != LONG_M1) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  // Counter register, async active-low reset
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign ts = (cnt_q >= SHORT_M1);
  assign tl = (cnt_q == LONG_M1);

endmodule

`default_nettype wire

// File: rtl/traffic_ctrl_timed.sv
// ============================================================================
// Module      : traffic_ctrl_timed
// Description : Highway/farm-road intersection controller with internal
//               interval timing. Lamps are a Moore decode of the state
//               register; ST pulses in the cycle before every transition.
//               Optional feature macro: TRAFFIC_PED_WALK_EN (pedestrian
//               request input, walk lamp, WK state, sticky pending flag).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module traffic_ctrl_timed
  import traffic_pkg::*;
#(
  parameter int SHORT_CYC = 3,
  parameter int LONG_CYC  = 10
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               C,
`ifdef TRAFFIC_PED_WALK_EN
  input  logic               ped_req,
  output logic               walk,
`endif
  output logic [2:0]         hw_lamp,
  output logic [2:0]         farm_lamp,
  output logic               ST,
  output logic [STATE_W-1:0] state
);

  localparam int SW = STATE_W;
  localparam logic [SW-1:0] S_HG = SW'(HG);
  localparam logic [SW-1:0] S_HY = SW'(HY);
  localparam logic [SW-1:0] S_FG = SW'(FG);
  localparam logic [SW-1:0] S_FY = SW'(FY);
`ifdef TRAFFIC_PED_WALK_EN
  localparam logic [SW-1:0] S_WK = SW'(WK);
`endif

  logic [SW-1:0] state_q;
  logic [SW-1:0] state_d;
  logic          ts;
  logic          tl;
  logic          hg_leave;

  // Timer restarts on the same edge that changes state
  traffic_timer #(
    .LONG_CYC  (LONG_CYC),
    .SHORT_CYC (SHORT_CYC)
  ) u_timer (
    .clk   (clk),
    .reset (reset),
    .clr   (ST),
    .ts    (ts),
    .tl    (tl)
  );

`ifdef TRAFFIC_PED_WALK_EN
  logic ped_pend_q;
  logic ped_pend_d;

  // Sticky request: set outside WK, cleared on WK exit; a new request wins
  always_comb begin
    ped_pend_d = ped_pend_q;
    if ((state_q == S_WK) && ST) begin
      ped_pend_d = 1'b0;
    end
    if (ped_req && (state_q != S_WK)) begin
      ped_pend_d = 1'b1;
    end
  end

  // Pending-request register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ped_pend_q <= 1'b0;
    end else begin
      ped_pend_q <= ped_pend_d;
    end
  end

  assign hg_leave = tl && (C || ped_pend_q);
`else
  assign hg_leave = tl && C;
`endif

  // State register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_HG;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic; unused encodings fall back to HG
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_HG: if (hg_leave) state_d = S_HY;
`ifdef TRAFFIC_PED_WALK_EN
      S_HY: if (ts) state_d = ped_pend_q ? S_WK : S_FG;
      S_WK: if (tl) state_d = C ? S_FG : S_HG;
`else
      S_HY: if (ts) state_d = S_FG;
`endif
      S_FG: if (tl || !C) state_d = S_FY;
      S_FY: if (ts) state_d = S_HG;
      default: state_d = S_HG;
    endcase
  end

  // Lamp decode from the state register only; default is all red
  always_comb begin
    hw_lamp   = RED;
    farm_lamp = RED;
`ifdef TRAFFIC_PED_WALK_EN
    walk      = 1'b0;
`endif
    case (state_q)
      S_HG: hw_lamp   = GRN;
      S_HY: hw_lamp   = YEL;
      S_FG: farm_lamp = GRN;
      S_FY: farm_lamp = YEL;
`ifdef TRAFFIC_PED_WALK_EN
      S_WK: walk      = 1'b1;
`endif
      default: ;
    endcase
  end

  assign ST    = (state_d != state_q);
  assign state = state_q;

endmodule

`default_nettype wire

// File: tb/tb_traffic_ctrl_timed.sv
// ============================================================================
// Module      : tb_traffic_ctrl_timed
// Description : Directed self-checking bench for traffic_ctrl_timed with
//               SHORT_CYC=3, LONG_CYC=5. Expected per-cycle outputs are
//               queued as stimulus is applied and popped at the negedge.
//               Optional feature macro: TRAFFIC_PED_WALK_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_traffic_ctrl_timed;
  import traffic_pkg::*;

  localparam int SHORT = 3;
  localparam int LONG  = 5;
  localparam int OW    = 3 + 3 + 1 + STATE_W + 1;

  typedef logic [OW-1:0] obs_t;

  logic               clk = 1'b0;
  logic               reset = 1'b0;
  logic               C = 1'b0;
  logic [2:0]         hw_lamp;
  logic [2:0]         farm_lamp;
  logic               ST;
  logic [STATE_W-1:0] state;
`ifdef TRAFFIC_PED_WALK_EN
  logic               ped_req = 1'b0;
  logic               walk;
`endif

  obs_t exp_q[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  always #5 clk = ~clk;

  traffic_ctrl_timed #(
    .SHORT_CYC (SHORT),
    .LONG_CYC  (LONG)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .C         (C),
`ifdef TRAFFIC_PED_WALK_EN
    .ped_req   (ped_req),
    .walk      (walk),
`endif
    .hw_lamp   (hw_lamp),
    .farm_lamp (farm_lamp),
    .ST        (ST),
    .state     (state)
  );

  // Observed outputs packed as {hw, farm, ST, state, walk}
  function automatic obs_t obs_now();
    logic w;
`ifdef TRAFFIC_PED_WALK_EN
    w = walk;
`else
    w = 1'b0;
`endif
    return {hw_lamp, farm_lamp, ST, state, w};
  endfunction

  // Expected outputs for a given state and strobe value
  function automatic obs_t expect_of(input int s, input logic st);
    logic [2:0] h;
    logic [2:0] f;
    h = 3'b100;
    f = 3'b100;
    case (s)
      0: h = 3'b001;
      1: h = 3'b010;
      2: f = 3'b001;
      3: f = 3'b010;
      default: ;
    endcase
    return {h, f, st, STATE_W'(s), (s == 4)};
  endfunction

  task automatic push_exp(input int s, input logic st);
    exp_q.push_back(expect_of(s, st));
  endtask

  task automatic check(input string tag);
    obs_t e;
    obs_t o;
    e = exp_q.pop_front();
    o = obs_now();
    n_cmp++;
    assert (o === e) else begin
      n_bad++;
      $error("FAIL %s: observed %b expected %b", tag, o, e);
    end
  endtask

  // One clock cycle: called just after a posedge, returns just after the next
  task automatic cyc(input logic c, input int s, input logic st, input string tag);
    C = c;
    push_exp(s, st);
    @(negedge clk);
    check(tag);
    @(posedge clk);
    #1;
  endtask

  // Expected state/strobe for cycle k after reset release with C held high
  task automatic full_cycle_step(input int k, input string tag);
    int   s;
    logic st;
    if (k < 5) begin s = HG; st = (k == 4); end
    else if (k < 8) begin s = HY; st = (k == 7); end
    else if (k < 13) begin s = FG; st = (k == 12); end
    else if (k < 16) begin s = FY; st = (k == 15); end
    else begin s = HG; st = 1'b0; end
    cyc(1'b1, s, st, tag);
  endtask

  initial begin
    // Reset hold with a car present, then idle highway green
    reset = 1'b0;
    C = 1'b1;
    @(posedge clk);
    #1;
    for (int i = 0; i < 2; i++) cyc(1'b1, HG, 1'b0, "rst_hold");
    reset = 1'b1;
    for (int i = 0; i < 20; i++) cyc(1'b0, HG, 1'b0, "idle_hg");

    // Late car with saturated timer, C pulsed low during yellow
    cyc(1'b1, HG, 1'b1, "late_car_st");
    cyc(1'b1, HY, 1'b0, "late_hy0");
    cyc(1'b0, HY, 1'b0, "late_hy1_clow");
    cyc(1'b1, HY, 1'b1, "late_hy2_st");

    // Early farm exit: car leaves two cycles into farm green
    cyc(1'b1, FG, 1'b0, "early_fg0");
    cyc(1'b1, FG, 1'b0, "early_fg1");
    cyc(1'b0, FG, 1'b1, "early_fg2_st");
    cyc(1'b0, FY, 1'b0, "early_fy0");
    cyc(1'b0, FY, 1'b0, "early_fy1");
    cyc(1'b0, FY, 1'b1, "early_fy2_st");
    for (int i = 0; i < 3; i++) cyc(1'b0, HG, 1'b0, "early_back_hg");

    // Full cycle from reset release with C held
    reset = 1'b0;
    #1;
    push_exp(HG, 1'b0);
    check("async_rst");
    @(posedge clk);
    #1;
    reset = 1'b1;
    for (int k = 0; k <= 16; k++) full_cycle_step(k, "full_cycle");

    // Reset asserted between edges in the middle of farm yellow
    reset = 1'b0;
    @(posedge clk);
    #1;
    reset = 1'b1;
    for (int k = 0; k < 14; k++) full_cycle_step(k, "to_fy");
    #2;
    reset = 1'b0;
    #1;
    push_exp(HG, 1'b0);
    check("rst_mid_fy");
    n_cmp++;
    assert (dut.u_timer.cnt_q === '0) else begin
      n_bad++;
      $error("FAIL rst_mid_fy_cnt: observed %0d expected 0", dut.u_timer.cnt_q);
    end
    @(posedge clk);
    #1;
    reset = 1'b1;
    for (int i = 0; i < 3; i++) cyc(1'b0, HG, 1'b0, "post_rst_hg");

`ifdef TRAFFIC_PED_WALK_EN
    // Pedestrian request pulse with no farm car
    reset = 1'b0;
    @(posedge clk);
    #1;
    reset = 1'b1;
    ped_req = 1'b1;
    C = 1'b0;
    push_exp(HG, 1'b0);
    @(negedge clk);
    check("ped_hg0");
    @(posedge clk);
    #1;
    ped_req = 1'b0;
    for (int k = 1; k < 4; k++) cyc(1'b0, HG, 1'b0, "ped_hg");
    cyc(1'b0, HG, 1'b1, "ped_hg_st");
    cyc(1'b0, HY, 1'b0, "ped_hy");
    cyc(1'b0, HY, 1'b0, "ped_hy");
    cyc(1'b0, HY, 1'b1, "ped_hy_st");
    for (int k = 0; k < 4; k++) cyc(1'b0, WK, 1'b0, "ped_wk");
    cyc(1'b0, WK, 1'b1, "ped_wk_st");
    for (int k = 0; k < 6; k++) cyc(1'b0, HG, 1'b0, "ped_back_hg");
    n_cmp++;
    assert (dut.ped_pend_q === 1'b0) else begin
      n_bad++;
      $error("FAIL ped_pend_clear: observed %b expected 0", dut.ped_pend_q);
    end
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

`default_nettype wire
